// File: rtl/free_game_award_unit.sv
// Free-game award: latches one award per player per game, queues
// them, and emits spaced BONUS_COIN pulses plus an optional tone.
//
// Ports:
//   CLK_DRV, RESET   clock, synchronous active-high reset
//   THRESH, SCORE    threshold and per-player score-hundreds digits
//   START_GAME_N     active-low game start, rearms all players
//   ATTRACT_N        active-low attract mode, kills the tone
//   TONE_GATE        audio carrier gated onto FREE_GAME_TONE
//   BONUS_COIN       one fixed-width pulse per award
//   AWARDED          per-player award-taken flags
//   FREE_GAME_TONE   TONE_GATE while the tone timer runs
// Build option: define FREE_GAME_TONE_EN to build the tone timer;
// otherwise FREE_GAME_TONE is tied low.
module free_game_award_unit #(
  parameter int PLAYERS      = 2,
  parameter int DIGIT_W      = 4,
  parameter int PULSE_CYCLES = 64,
  parameter int TONE_COUNTS  = 66206432
) (
  input  logic                       CLK_DRV,
  input  logic                       RESET,
  input  logic [DIGIT_W-1:0]         THRESH,
  input  logic [PLAYERS*DIGIT_W-1:0] SCORE,
  input  logic                       START_GAME_N,
  input  logic                       ATTRACT_N,
  input  logic                       TONE_GATE,
  output logic                       BONUS_COIN,
  output logic [PLAYERS-1:0]         AWARDED,
  output logic                       FREE_GAME_TONE
);

  localparam int PW = $clog2(PLAYERS + 1) + 1;
  localparam int CW =
    (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [PW:0] MAXP = (PW + 1)'(2 * PLAYERS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [PW-1:0]      pend_q, pend_d;
  logic [PW-1:0]      n_new;
  logic [PW:0]        sum;
  logic [PLAYERS-1:0] award;
  logic [PLAYERS-1:0] awarded_d;
  logic               enter;
  logic               coin_q;

  always_comb begin
    award = '0;
    n_new = '0;
    for (int i = 0; i < PLAYERS; i++) begin
      award[i] = (THRESH != '0)
        && (SCORE[i*DIGIT_W +: DIGIT_W] == THRESH)
        && !AWARDED[i] && START_GAME_N;
      n_new = n_new + PW'(award[i]);
    end
  end

  // Start wins over a same-cycle award.
  always_comb begin
    awarded_d = AWARDED | award;
    if (!START_GAME_N)
      awarded_d = '0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    enter   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pend_q != '0) begin
          state_d = PULSE;
          cnt_d   = '0;
          enter   = 1'b1;
        end
      end
      PULSE: begin
        if (cnt_q == LAST) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (pend_q != '0) begin
            state_d = PULSE;
            enter   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Award and dequeue in the same edge net out; enter implies
  // pend_q >= 1, so the sum never underflows.
  always_comb begin
    sum = {1'b0, pend_q} + {1'b0, n_new}
        - {{PW{1'b0}}, enter};
    pend_d = (sum > MAXP) ? MAXP[PW-1:0] : sum[PW-1:0];
  end

  always_ff @(posedge CLK_DRV) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      AWARDED <= '0;
      coin_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      AWARDED <= awarded_d;
      coin_q  <= (state_d == PULSE);
    end
  end

  assign BONUS_COIN = coin_q;

`ifdef FREE_GAME_TONE_EN
  localparam int TW = $clog2(TONE_COUNTS + 1);
  logic [TW-1:0] tone_q;

  always_ff @(posedge CLK_DRV) begin
    if (RESET)
      tone_q <= '0;
    else if (!ATTRACT_N)
      tone_q <= '0;
    else if (enter)
      tone_q <= TW'(TONE_COUNTS);
    else if (tone_q != '0)
      tone_q <= tone_q - 1'b1;
  end

  assign FREE_GAME_TONE = TONE_GATE && (tone_q != '0);
`else
  logic unused_tone;
  assign unused_tone    = TONE_GATE ^ ATTRACT_N;
  assign FREE_GAME_TONE = 1'b0;
`endif

endmodule
